// File: rtl/theremin_tone.sv
// theremin_tone: turns HC-SR04 echo widths (in 1 us counts) into a square-wave tone.
// Each in-range echo width passes through a 4-sample moving average and is then
// mapped linearly to a half-period in clk_in cycles. The tone counter picks up a
// new half-period only at a half-cycle boundary, so period changes never glitch
// the output. Repeated out-of-range readings (no hand present) mute the tone.
module theremin_tone #(
    parameter int MIN_US    = 116,    // smallest in-range echo width (~2 cm)
    parameter int MAX_US    = 2900,   // largest in-range echo width (~50 cm)
    parameter int HP_MIN    = 25000,  // half-period at MIN_US, clk_in cycles
    parameter int HP_SCALE  = 16,     // half-period cycles added per us above MIN_US
    parameter int OOR_LIMIT = 3       // consecutive out-of-range samples before mute (1..15)
) (
    input  logic        clk_in,
    input  logic        clear,
    input  logic [31:0] echo_us,
    input  logic        echo_valid,
    input  logic        enable,
    output logic        tone_out,
    output logic        muted,
    output logic [19:0] half_period
);

    // In-range samples never exceed MAX_US, so 12 bits hold one and 14 bits
    // hold the sum of four.
    localparam int SAMPLE_W = 12;
    localparam int SUM_W    = 14;

    localparam logic [31:0]         MIN_US_W   = 32'(MIN_US);
    localparam logic [31:0]         MAX_US_W   = 32'(MAX_US);
    localparam logic [19:0]         HP_MIN_W   = 20'(HP_MIN);
    localparam logic [19:0]         HP_SCALE_W = 20'(HP_SCALE);
    localparam logic [19:0]         HP_BASE_W  = 20'(MIN_US);
    localparam logic [3:0]          OOR_MAX    = 4'(OOR_LIMIT);

    // ------------------------------------------------------------------
    // Stage 0: range check on the strobe cycle
    // ------------------------------------------------------------------
    logic                in_range;
    logic [SAMPLE_W-1:0] sample;
    logic [3:0]          oor_cnt;
    logic [3:0]          oor_inc;

    assign in_range = (echo_us >= MIN_US_W) && (echo_us <= MAX_US_W);
    assign sample   = echo_us[SAMPLE_W-1:0];
    assign oor_inc  = oor_cnt + 4'd1;

    // Out-of-range counter and mute flag; any in-range sample unmutes at once.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            oor_cnt <= 4'd0;
            muted   <= 1'b1;
        end else if (echo_valid) begin
            if (in_range) begin
                oor_cnt <= 4'd0;
                muted   <= 1'b0;
            end else if (oor_cnt < OOR_MAX) begin
                oor_cnt <= oor_inc;
                if (oor_inc == OOR_MAX) begin
                    muted <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 4-entry moving-average buffer
    // ------------------------------------------------------------------
    logic [3:0][SAMPLE_W-1:0] avg_buf;   // [0] is the newest sample
    logic                     fill_done;
    logic                     upd_pend;  // buffer changed; half_period recomputes next edge
    logic [SUM_W-1:0]         avg_sum;
    logic [SAMPLE_W-1:0]      avg;

    // Write accepted samples; the first one after clear fills every entry so the
    // average starts at the first reading instead of ramping up from zero.
    // NOTE: this register array is reset explicitly because the average reads
    // every entry; an unreset array would feed X into half_period.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            avg_buf   <= '0;
            fill_done <= 1'b0;
            upd_pend  <= 1'b0;
        end else begin
            upd_pend <= echo_valid && in_range;
            if (echo_valid && in_range) begin
                fill_done <= 1'b1;
                if (fill_done) begin
                    avg_buf <= {avg_buf[2:0], sample};
                end else begin
                    avg_buf <= {4{sample}};
                end
            end
        end
    end

    assign avg_sum = SUM_W'(avg_buf[0]) + SUM_W'(avg_buf[1])
                   + SUM_W'(avg_buf[2]) + SUM_W'(avg_buf[3]);
    assign avg     = SAMPLE_W'(avg_sum >> 2);

    // ------------------------------------------------------------------
    // Stage 2: linear map from averaged distance to half-period
    // ------------------------------------------------------------------
    logic [19:0] hp_calc;

    // Buffer entries are all in range, so avg >= MIN_US and the subtraction
    // cannot wrap.
    assign hp_calc = HP_MIN_W + (20'(avg) - HP_BASE_W) * HP_SCALE_W;

    // Register the mapped half-period one edge after the buffer updates.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            half_period <= HP_MIN_W;
        end else if (upd_pend) begin
            half_period <= hp_calc;
        end
    end

    // ------------------------------------------------------------------
    // Tone generator
    // ------------------------------------------------------------------
    logic        silent;
    logic [19:0] tone_cnt;
    logic [19:0] hp_active;   // half-period of the half-cycle in progress
    logic        tone_last;

    assign silent    = muted || !enable;
    assign tone_last = (tone_cnt == hp_active - 20'd1);

    // Count out each half-cycle; load the next length only at the boundary.
    // While silent the counter parks at zero and tracks half_period, so the
    // first rise after leaving silence comes one full half-period later.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            tone_out  <= 1'b0;
            tone_cnt  <= 20'd0;
            hp_active <= HP_MIN_W;
        end else if (silent) begin
            tone_out  <= 1'b0;
            tone_cnt  <= 20'd0;
            hp_active <= half_period;
        end else if (tone_last) begin
            tone_out  <= !tone_out;
            tone_cnt  <= 20'd0;
            hp_active <= half_period;
        end else begin
            tone_cnt  <= tone_cnt + 20'd1;
        end
    end

endmodule

// File: doc/theremin_tone.md
Name: theremin_tone

Overview:
- Downstream consumer of the HC-SR04 echo-width measurement (echo pulse width in 1 us counts).
- Validates each new measurement against a usable hand-distance window and smooths it with a 4-sample moving average.
- Maps the averaged distance linearly to a square-wave half-period and drives a glitch-free audio tone to the speaker pin.
- Mutes after repeated out-of-range readings (no hand present).

Parameters:
- MIN_US, 116: smallest in-range echo width (≈2 cm).
- MAX_US, 2900: largest in-range echo width (≈50 cm).
- HP_MIN, 25000: half-period in clk_in cycles at MIN_US (1 kHz at 50 MHz).
- HP_SCALE, 16: half-period clk_in cycles added per us above MIN_US.
- OOR_LIMIT, 3: consecutive out-of-range samples before mute (1..15).

Ports:
- clk_in  input  1  system clock, 50 MHz
- clear  input  1  synchronous active-high reset
- echo_us  input  32  measured echo width, us
- echo_valid  input  1  one-cycle strobe; echo_us is valid this cycle
- enable  input  1  tone enable; low forces silence
- tone_out  output  1  square-wave audio output
- muted  output  1  high while silenced by out-of-range logic
- half_period  output  20  current target half-period, clk_in cycles

Behaviour:
- Single clock domain, clk_in; clear is sampled synchronously and is active-high.
- Reset values:
  - tone_out=0, muted=1, half_period=HP_MIN.
  - Average buffer all zero; fill flag=0; OOR counter=0; tone counter=0.
- Range check, evaluated on the echo_valid cycle (stage 0):
  - In range means MIN_US <= echo_us <= MAX_US, compared over all 32 bits; both bounds are inclusive.
  - Out-of-range sample: OOR counter increments, saturating at OOR_LIMIT. When it reaches OOR_LIMIT, muted=1 on the next edge. The buffer and half_period are untouched.
  - In-range sample: OOR counter cleared, muted=0 on the next edge, sample passed to the filter.
- Filter, stage 1 (edge after echo_valid):
  - Fill flag 0: the sample is written into all 4 entries and the fill flag is set. This avoids a start-up ramp.
  - Fill flag 1: 4-entry shift; sum is 14 bits; avg = sum >> 2 (truncating).
  - muted does not clear the fill flag; only clear does.
- Mapping, stage 2 (second edge after echo_valid):
  - half_period = HP_MIN + (avg − MIN_US) * HP_SCALE, computed in 20 bits.
  - No overflow is possible with the default parameters; max is 69544.
- Latency: echo_valid at cycle N gives updated half_period visible at N+2.
- Back-to-back echo_valid strobes are accepted every cycle (fully pipelined).
- Tone generator:
  - The counter runs 0..hp_active−1.
  - At the terminal count: tone_out toggles, the counter returns to 0, and hp_active is loaded from half_period.
  - A half_period change mid half-cycle therefore takes effect only from the next half-cycle (glitch-free).
- Silence: when muted=1 or enable=0, tone_out=0, the counter is held at 0, and hp_active=half_period.
  - On leaving silence, the first rising edge of tone_out occurs hp_active cycles later.
- Simultaneous events:
  - clear dominates echo_valid and enable.
  - An out-of-range sample arriving while an in-range sample is in stages 1–2 does not cancel it; half_period still updates.
- clear mid-operation: all state returns to reset values on the next edge; any pipeline contents are discarded.

Test Plan:
1. Assert clear 2 cycles, enable=1 → tone_out=0, muted=1, half_period=25000. No toggles for 100k cycles.
2. Pulse echo_valid with echo_us=116 → at N+2, half_period=25000 and muted=0. tone_out toggles every 25000 cycles (1 kHz). Repeat with echo_us=2900 → half_period=69544.
3. First sample echo_us=1116 (preload) → half_period=41000. Next sample 2116 → avg=1366 → 45000. Three more 2116 samples → 57000.
4. Send three echo_us=5000 samples → muted=1 after the third, tone_out=0 on the following edge.
   - Two samples of 5000 then one of 1116 → muted never asserts.
   - echo_us=115 and echo_us=2901 both count as out of range.
5. Change half_period from 25000 to 41000 at cycle 10000 of a half-cycle → that half lasts 25000 cycles; subsequent halves last 41000.
6. Deassert enable mid-tone → tone_out=0 next edge. Reassert → first rise after exactly half_period cycles. Assert clear during stage 1 of a pending sample → half_period stays at 25000.
